// File: rtl/ifetch_unit.sv
// ifetch_unit
// Instruction-fetch stage of the multi-cycle MIPS core. It holds the PC and
// fetches one instruction per pass over a valid/ready memory interface. It
// latches the word into the instruction register and shows the decoder its
// opcode/Function fields. When the datapath reports ex_done, it computes the
// next PC from the decoder's PC_control vector.
//
// Handshake rule for both memory channels: a transfer happens on a rising
// edge where valid and ready are both high. inst_req_valid is asserted only
// in IF_REQ, and inst_resp_ready only in IF_WAIT. The unit ignores
// inst_req_ready, inst_resp_valid and ex_done in any other state.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   inst_req_valid/ready, inst_addr     fetch request channel (addr == pc)
//   inst_resp_valid/ready, inst_rdata   fetch response channel
//   ir, opcode, Function, ir_valid      instruction register to decoder
//   pc                address of the instruction in ir
//   ex_done, PC_control, zero, jr_target  completion and next-PC controls
//   state_dbg         current FSM state (BOOT=0, IF_REQ=1, IF_WAIT=2, HOLD=3)
//
// Optional feature: define IFETCH_PERF_EN to add perf_inst_cnt (retired
// instructions) and perf_wait_cnt (memory stall cycles) outputs.

module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req_valid,
    input  logic        inst_req_ready,
    output logic [31:0] inst_addr,
    input  logic        inst_resp_valid,
    output logic        inst_resp_ready,
    input  logic [31:0] inst_rdata,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [5:0]  Function,
    output logic        ir_valid,
    output logic [31:0] pc,
    input  logic        ex_done,
    input  logic [3:0]  PC_control,
    input  logic        zero,
    input  logic [31:0] jr_target,
    output logic [1:0]  state_dbg
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_inst_cnt,
    output logic [31:0] perf_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] next_pc;

    // The jr target is forced word-aligned, so its low bits are never used.
    logic unused_jr_bits;
    assign unused_jr_bits = ^jr_target[1:0];

    // State register, ir and pc
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
            ir    <= 32'h0;
        end else begin
            state <= state_next;
            if (state == IF_WAIT && inst_resp_valid) begin
                ir <= inst_rdata;
            end
            if (state == HOLD && ex_done) begin
                pc <= next_pc;
            end
        end
    end

    // Next state and control outputs. The outputs depend only on the
    // registered state.
    always_comb begin
        state_next      = state;
        inst_req_valid  = 1'b0;
        inst_resp_ready = 1'b0;
        ir_valid        = 1'b0;
        case (state)
            BOOT: begin
                state_next = IF_REQ;
            end
            IF_REQ: begin
                inst_req_valid = 1'b1;
                if (inst_req_ready) begin
                    state_next = IF_WAIT;
                end
            end
            IF_WAIT: begin
                inst_resp_ready = 1'b1;
                if (inst_resp_valid) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                ir_valid = 1'b1;
                if (ex_done) begin
                    state_next = IF_REQ;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // Next-PC selection. If more than one PC_control bit is set, the
    // priority is jr > jal > bne > beq. A selected branch whose condition
    // fails falls through to pc4. It does not fall to a lower-priority bit.
    always_comb begin
        pc4     = pc + 32'd4;
        br_off  = {{14{ir[15]}}, ir[15:0], 2'b00};
        next_pc = pc4;
        if (PC_control[3]) begin
            next_pc = {jr_target[31:2], 2'b00};
        end else if (PC_control[2]) begin
            next_pc = {pc4[31:28], ir[25:0], 2'b00};
        end else if (PC_control[1]) begin
            if (!zero) begin
                next_pc = pc4 + br_off;
            end
        end else if (PC_control[0]) begin
            if (zero) begin
                next_pc = pc4 + br_off;
            end
        end
    end

    assign inst_addr = pc;
    assign opcode    = ir[31:26];
    assign Function  = ir[5:0];
    assign state_dbg = state;

`ifdef IFETCH_PERF_EN
    // Performance counters. Both wrap at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_inst_cnt <= 32'h0;
            perf_wait_cnt <= 32'h0;
        end else begin
            if (state == HOLD && ex_done) begin
                perf_inst_cnt <= perf_inst_cnt + 32'd1;
            end
            if ((state == IF_REQ && !inst_req_ready) ||
                (state == IF_WAIT && !inst_resp_valid)) begin
                perf_wait_cnt <= perf_wait_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit. Inputs are driven and outputs are
// sampled on the falling clock edge.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req_valid;
  logic        inst_req_ready = 1'b0;
  logic [31:0] inst_addr;
  logic        inst_resp_valid = 1'b0;
  logic        inst_resp_ready;
  logic [31:0] inst_rdata = 32'h0;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic [5:0]  Function;
  logic        ir_valid;
  logic [31:0] pc;
  logic        ex_done = 1'b0;
  logic [3:0]  PC_control = 4'h0;
  logic        zero = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic [1:0]  state_dbg;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_inst_cnt;
  logic [31:0] perf_wait_cnt;
`endif

  ifetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
    .inst_addr(inst_addr),
    .inst_resp_valid(inst_resp_valid), .inst_resp_ready(inst_resp_ready),
    .inst_rdata(inst_rdata),
    .ir(ir), .opcode(opcode), .Function(Function), .ir_valid(ir_valid),
    .pc(pc), .ex_done(ex_done), .PC_control(PC_control), .zero(zero),
    .jr_target(jr_target), .state_dbg(state_dbg)
`ifdef IFETCH_PERF_EN
    , .perf_inst_cnt(perf_inst_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_ir;
  int          m_inst;
  int          m_wait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    inst_req_ready = 1'b0; inst_resp_valid = 1'b0; ex_done = 1'b0;
    PC_control = 4'h0; zero = 1'b0; jr_target = 32'h0; inst_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, RESET_PC);
    check("rst_inst_addr", inst_addr, RESET_PC);
    check("rst_ir", ir, 32'h0);
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_function", 32'(Function), 32'h0);
    check("rst_req_valid", 32'(inst_req_valid), 32'h0);
    check("rst_resp_ready", 32'(inst_resp_ready), 32'h0);
    check("rst_ir_valid", 32'(ir_valid), 32'h0);
`ifdef IFETCH_PERF_EN
    check("rst_perf_inst", perf_inst_cnt, 32'h0);
    check("rst_perf_wait", perf_wait_cnt, 32'h0);
`endif
    rst = 1'b0;
    cur_ir = 32'h0;
    m_inst = 0;
    m_wait = 0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!inst_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_valid"}, 32'(inst_req_valid), 32'h1);
  endtask

  // One fetch: req_wait stall cycles before acceptance, then resp_wait
  // cycles before the response. Ends in HOLD.
  task automatic fetch(input logic [31:0] word, input int req_wait, input int resp_wait,
                       input logic [31:0] exp_addr, input string tag);
    wait_req(tag);
    check({tag, "_addr"}, inst_addr, exp_addr);
    for (int i = 0; i < req_wait; i++) begin
      inst_req_ready = 1'b0;
      @(negedge clk);
      check({tag, "_addr_stable_req"}, inst_addr, exp_addr);
    end
    inst_req_ready = 1'b1;
    @(negedge clk);
    inst_req_ready = 1'b0;
    check({tag, "_resp_ready"}, 32'(inst_resp_ready), 32'h1);
    for (int i = 0; i < resp_wait; i++) begin
      @(negedge clk);
      check({tag, "_addr_stable_resp"}, inst_addr, exp_addr);
      check({tag, "_ir_stable"}, ir, cur_ir);
    end
    inst_resp_valid = 1'b1;
    inst_rdata = word;
    @(negedge clk);
    inst_resp_valid = 1'b0;
    inst_rdata = $urandom;
    cur_ir = word;
    m_wait += req_wait + resp_wait;
    check({tag, "_ir"}, ir, word);
    check({tag, "_opcode"}, 32'(opcode), 32'(word[31:26]));
    check({tag, "_function"}, 32'(Function), 32'(word[5:0]));
    check({tag, "_ir_valid"}, 32'(ir_valid), 32'h1);
    check({tag, "_pc"}, pc, exp_addr);
  endtask

  // Complete the held instruction. The controls carry garbage during the
  // wait cycles and only hold real values on the ex_done edge.
  task automatic execute(input logic [3:0] ctl, input logic z, input logic [31:0] jt,
                         input int ex_wait);
    for (int i = 0; i < ex_wait; i++) begin
      PC_control = 4'($urandom); zero = 1'($urandom); jr_target = $urandom;
      ex_done = 1'b0;
      @(negedge clk);
      check("hold_ir_valid", 32'(ir_valid), 32'h1);
    end
    PC_control = ctl; zero = z; jr_target = jt; ex_done = 1'b1;
    @(negedge clk);
    ex_done = 1'b0;
    PC_control = 4'($urandom); zero = 1'($urandom); jr_target = $urandom;
    m_inst++;
    check("post_exec_ir_valid", 32'(ir_valid), 32'h0);
  endtask

  // Reference next-PC rule written as plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cpc, input logic [31:0] word,
                                             input logic [3:0] ctl, input logic z,
                                             input logic [31:0] jt);
    logic [31:0] pc4;
    int          off;
    pc4 = cpc + 32'd4;
    off = int'($signed(word[15:0])) * 4;
    if (ctl[3])      return jt & 32'hFFFF_FFFC;
    else if (ctl[2]) return (pc4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    else if (ctl[1]) return (!z) ? pc4 + 32'(off) : pc4;
    else if (ctl[0]) return z ? pc4 + 32'(off) : pc4;
    return pc4;
  endfunction

  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] instr;
    logic [3:0]  ctl;
    logic        z;
    logic [31:0] jt;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] cur;
    logic [31:0] word;
    logic [31:0] nxt;
    logic [3:0]  ctl;
    logic        z;
    logic [31:0] jt;

    vecs[0]  = '{32'h0000_0100, 32'h1000_FFFF, 4'b0001, 1'b1, 32'h0, 32'h0000_0100};
    vecs[1]  = '{32'h0000_0100, 32'h1000_FFFF, 4'b0001, 1'b0, 32'h0, 32'h0000_0104};
    vecs[2]  = '{32'h0040_0000, 32'h0C00_0040, 4'b0100, 1'b0, 32'h0, 32'h0000_0100};
    vecs[3]  = '{32'h0000_0200, 32'h03E0_0008, 4'b1000, 1'b0, 32'h0040_0023, 32'h0040_0020};
    vecs[4]  = '{32'h0000_0300, 32'h1000_FFFF, 4'b1001, 1'b1, 32'h0000_0080, 32'h0000_0080};
    vecs[5]  = '{32'h0000_1000, 32'h1400_0010, 4'b0010, 1'b0, 32'h0, 32'h0000_1044};
    vecs[6]  = '{32'h0000_1000, 32'h1400_0010, 4'b0010, 1'b1, 32'h0, 32'h0000_1004};
    vecs[7]  = '{32'h9000_0000, 32'h0C00_0040, 4'b0110, 1'b0, 32'h0, 32'h9000_0100};
    vecs[8]  = '{32'h0000_2000, 32'h1000_0005, 4'b0011, 1'b1, 32'h0, 32'h0000_2004};
    vecs[9]  = '{32'hFFFF_FFFC, 32'h0000_0000, 4'b0000, 1'b0, 32'h0, 32'h0000_0000};
    vecs[10] = '{32'h0000_0500, 32'h1000_8000, 4'b0001, 1'b1, 32'h0, 32'hFFFE_0504};

    // Zero-wait memory with ex_done held high: one fetch every 3 cycles.
    do_reset();
    check("boot_req_valid", 32'(inst_req_valid), 32'h0);
    inst_req_ready = 1'b1; inst_resp_valid = 1'b1; inst_rdata = 32'h0;
    PC_control = 4'h0; ex_done = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("seq_req_valid", 32'(inst_req_valid), 32'((k % 3) == 1));
      check("seq_ir_valid", 32'(ir_valid), 32'((k % 3) == 0));
      if ((k % 3) == 1) check("seq_addr", inst_addr, RESET_PC + 32'(4 * ((k - 1) / 3)));
    end
    inst_req_ready = 1'b0; inst_resp_valid = 1'b0; ex_done = 1'b0;

    // Stalls: 4 request wait cycles and 2 response wait cycles.
    do_reset();
    fetch(32'h2108_0001, 4, 2, RESET_PC, "stall");
`ifdef IFETCH_PERF_EN
    check("stall_perf_wait", perf_wait_cnt, 32'd6);
`endif

    // Reset while in IF_WAIT; a response arriving after reset is ignored.
    do_reset();
    wait_req("rstw");
    inst_req_ready = 1'b1;
    @(negedge clk);
    inst_req_ready = 1'b0;
    check("rstw_in_wait", 32'(inst_resp_ready), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    inst_resp_valid = 1'b1;
    inst_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstw_ir", ir, 32'h0);
      check("rstw_addr", inst_addr, RESET_PC);
      check("rstw_ir_valid", 32'(ir_valid), 32'h0);
    end
    inst_resp_valid = 1'b0;
    cur_ir = 32'h0;
    fetch(32'h0000_0020, 0, 0, RESET_PC, "rstw_refetch");

    // Table-driven next-PC vectors: jump to start_pc with jr, then run the
    // vector instruction there.
    do_reset();
    cur = RESET_PC;
    for (int v = 0; v < 11; v++) begin
      fetch(32'h0000_0000, 0, 0, cur, "vec_pre");
      execute(4'b1000, 1'b0, vecs[v].start_pc, 0);
      fetch(vecs[v].instr, 0, 0, vecs[v].start_pc, "vec_start");
      execute(vecs[v].ctl, vecs[v].z, vecs[v].jt, 0);
      cur = vecs[v].exp_next;
    end

    // Randomized instructions, controls and wait cycles against the model.
    exp_q.push_back(cur);
    for (int i = 0; i < 60; i++) begin
      word = $urandom;
      ctl  = 4'($urandom_range(0, 15));
      z    = 1'($urandom_range(0, 1));
      jt   = $urandom;
      cur  = exp_q.pop_front();
      fetch(word, $urandom_range(0, 3), $urandom_range(0, 3), cur, "rand");
      nxt = model_next(cur, word, ctl, z, jt);
      execute(ctl, z, jt, $urandom_range(0, 3));
      exp_q.push_back(nxt);
    end
    wait_req("rand_final");
    check("rand_final_addr", inst_addr, exp_q.pop_front());
`ifdef IFETCH_PERF_EN
    check("perf_inst_total", perf_inst_cnt, 32'(m_inst));
    check("perf_wait_total", perf_wait_cnt, 32'(m_wait));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage of the multi-cycle MIPS core, directly upstream of the opcode/function decoder. It holds the PC, fetches one 32-bit instruction at a time over a valid/ready memory interface, and latches it into the instruction register. It presents `opcode`/`Function` fields to the decoder, then computes the next PC from the decoder's 4-bit `PC_control` vector when the datapath signals completion.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded by reset.
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_req_valid`  out  1  fetch request valid.
- `inst_req_ready`  in  1  memory accepts the request.
- `inst_addr`  out  32  fetch address; always equals `pc`.
- `inst_resp_valid`  in  1  instruction data valid.
- `inst_resp_ready`  out  1  unit can accept the response.
- `inst_rdata`  in  32  fetched instruction word.
- `ir`  out  32  instruction register.
- `opcode`  out  6  `ir[31:26]`.
- `Function`  out  6  `ir[5:0]`.
- `ir_valid`  out  1  `ir` holds a live instruction awaiting execution.
- `pc`  out  32  address of the instruction in `ir`.
- `ex_done`  in  1  datapath has finished the instruction in `ir`.
- `PC_control`  in  4  bit0 beq, bit1 bne, bit2 jal, bit3 jr.
- `zero`  in  1  ALU zero flag for the current branch.
- `jr_target`  in  32  rs register value for jr.

## Operation
- FSM states: BOOT, IF_REQ, IF_WAIT, HOLD.
- BOOT goes to IF_REQ unconditionally on the next edge.
- IF_REQ:
  - `inst_req_valid`=1.
  - Moves to IF_WAIT on the edge where `inst_req_valid & inst_req_ready`.
- IF_WAIT:
  - `inst_resp_ready`=1.
  - On the edge where `inst_resp_valid` is high: `ir` is loaded with `inst_rdata` and the FSM moves to HOLD.
- HOLD:
  - `ir_valid`=1.
  - On the edge where `ex_done` is high: `pc` is loaded with next_pc and the FSM moves to IF_REQ.
- Next-PC computation (pc4 = pc+4, modulo 2^32):
  - jr: `{jr_target[31:2],2'b00}`.
  - jal: `{pc4[31:28], ir[25:0], 2'b00}`.
  - bne with `zero`=0, or beq with `zero`=1: pc4 + (sign_extend(`ir[15:0]`)<<2).
  - Otherwise: pc4.
- Multiple `PC_control` bits set (illegal): priority is jr > jal > bne > beq.
- The core has no branch delay slot.
- `inst_resp_valid` outside IF_WAIT is ignored.
- `ex_done` outside HOLD is ignored.
- `inst_req_ready` outside IF_REQ is ignored.
- `ir`, `pc` and `inst_addr` are stable in every cycle they are not being loaded.

## Timing
- Reset values:
  - state BOOT; `pc`=`inst_addr`=RESET_PC; `ir`=0 (so `opcode`=`Function`=0).
  - `inst_req_valid`=`inst_resp_ready`=`ir_valid`=0.
- Control outputs are decoded from the registered state only; no combinational path from inputs to outputs.
- First request appears in the 2nd cycle after `rst` deasserts.
- Minimum per instruction is 3 cycles (IF_REQ, IF_WAIT and HOLD each last ≥1 cycle); each extra wait cycle on `inst_req_ready`, `inst_resp_valid` or `ex_done` adds exactly 1 cycle.
- Memory may return data no earlier than the cycle after request acceptance.
- `PC_control`, `zero` and `jr_target` are sampled only on the `ex_done` edge.
- `rst` asserted in any state:
  - The next edge forces the reset values.
  - An in-flight memory response is discarded; memory must tolerate a request abandoned by reset.

## Configuration
- `IFETCH_PERF_EN` defined adds two outputs, each reset to 0 and wrapping at 2^32:
  - `perf_inst_cnt` (32): +1 on every `ex_done` edge in HOLD.
  - `perf_wait_cnt` (32): +1 every cycle in IF_REQ with `inst_req_ready`=0, or in IF_WAIT with `inst_resp_valid`=0.
- Macro undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, zero-wait memory, RESET_PC=0, `ex_done` held high → `inst_addr` sequence 0x0, 0x4, 0x8, one fetch every 3 cycles; first `inst_req_valid` in the 2nd cycle after reset.
- beq, `ir`=0x1000FFFF at pc=0x100, `zero`=1 → next `inst_addr`=0x100; same with `zero`=0 → 0x104.
- jal 0x0C000040 at pc=0x00400000 → next `inst_addr`=0x00000100; jr with `jr_target`=0x00400023 → 0x00400020.
- `inst_req_ready` low 4 cycles, then `inst_resp_valid` after 2 cycles → `inst_addr` stable throughout; `ir` loads on the response edge; `perf_wait_cnt`=6 when `IFETCH_PERF_EN` is defined.
- `PC_control`=4'b1001 (jr+beq), `zero`=1, `jr_target`=0x80 → next `inst_addr`=0x80.
- `rst` pulsed in IF_WAIT, then `inst_resp_valid` arrives after reset → response ignored; `ir`=0; fetch restarts at RESET_PC.
